// File: rtl/prog_loader.sv
// prog_loader
//   Loads a framed program image (LEN, N data bytes, CHK) from a valid/ready
//   byte stream into program memory starting at address 0. When the 8-bit
//   checksum matches, the CPU is released to run. Until a good load completes,
//   the CPU is held stopped.
//
// Ports
//   clk        rising-edge clock, shared with the CPU
//   rst_n      asynchronous active-low reset
//   in_valid   source presents a byte
//   in_data    byte from source
//   in_ready   loader accepts a byte this cycle (combinational)
//   reload     single-cycle abort/restart request
//   mem_we     memory write strobe, one cycle per data byte (registered)
//   mem_addr   memory write address (registered, holds last value)
//   mem_wdata  memory write data (registered, holds last value)
//   cpu_run    1 = CPU may execute
//   load_err   checksum mismatch on the last load
//   busy       frame in progress (LEN received, CHK not yet)
//
// State  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for the LEN byte
// LOAD   | receiving data bytes and writing them to memory
// CHECK  | waiting for the CHK byte
// RUN    | image verified, CPU released; waits for reload
// ERR    | checksum mismatch, CPU held; waits for reload
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              load_err,
  output logic              busy
);

  // Remaining-count width must hold both any LEN value and the full 2^ADDR_W.
  localparam int CNT_W = ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1;
  localparam logic [CNT_W-1:0] FULL_N = CNT_W'(1) << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  state_t            state_q,     state_d;
  logic [ADDR_W-1:0] addr_cnt_q,  addr_cnt_d;
  logic [DATA_W-1:0] sum_q,       sum_d;
  logic [CNT_W-1:0]  rem_q,       rem_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_run_q,   cpu_run_d;
  logic              load_err_q,  load_err_d;
  logic              busy_q,      busy_d;

  logic              accept;
  logic [CNT_W-1:0]  len_n;

  assign in_ready = ((state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                     (state_q == ST_CHECK)) && !reload;
  assign accept   = in_valid && in_ready;

  // LEN = 0 encodes a full-size image.
  assign len_n = (in_data == '0) ? FULL_N : CNT_W'(in_data);

  always_comb begin
    state_d     = state_q;
    addr_cnt_d  = addr_cnt_q;
    sum_d       = sum_q;
    rem_d       = rem_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (reload) begin
      // Memory is left as-is; only the loader bookkeeping restarts.
      state_d    = ST_IDLE;
      addr_cnt_d = '0;
      sum_d      = '0;
      rem_d      = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            rem_d      = len_n;
            addr_cnt_d = '0;
            sum_d      = '0;
            state_d    = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_cnt_q;
            mem_wdata_d = in_data;
            addr_cnt_d  = addr_cnt_q + ADDR_W'(1);
            sum_d       = sum_q + in_data;
            rem_d       = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_d = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (accept) begin
            state_d = (in_data == sum_q) ? ST_RUN : ST_ERR;
          end
        end
        ST_RUN, ST_ERR: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Status outputs are registered from the next state so they change on
    // the same edge as the state itself.
    cpu_run_d  = (state_d == ST_RUN);
    load_err_d = (state_d == ST_ERR);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_cnt_q  <= '0;
      sum_q       <= '0;
      rem_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_run_q   <= 1'b0;
      load_err_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_cnt_q  <= addr_cnt_d;
      sum_q       <= sum_d;
      rem_q       <= rem_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_run_q   <= cpu_run_d;
      load_err_q  <= load_err_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_run   = cpu_run_q;
  assign load_err  = load_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
//   Self-checking bench for prog_loader. Expected memory writes {addr, data}
//   are queued when a data byte is driven and popped by a write monitor when
//   the DUT pulses mem_we. Each scenario task checks status outputs inline.
module tb_prog_loader;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       reload;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_run;
  logic       load_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int writes   = 0;

  logic [15:0] sb[$];
  logic [15:0] mon_exp;

  prog_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reload    (reload),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_run   (cpu_run),
    .load_err  (load_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every mem_we pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      writes++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                 mem_addr, mem_wdata);
      end else begin
        mon_exp = sb.pop_front();
        if ({mem_addr, mem_wdata} !== mon_exp) begin
          failures++;
          $display("FAIL mem_write: got addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_wdata, mon_exp[15:8], mon_exp[7:0]);
        end
      end
    end
  end

  // Stimulus helpers: called at a falling edge, return at the next one.
  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
  endtask

  task automatic send_data(input logic [7:0] a, input logic [7:0] b);
    sb.push_back({a, b});
    send_byte(b);
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reload();
    in_valid = 1'b0;
    reload   = 1'b1;
    @(negedge clk);
    reload   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    reload   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_wdata, cpu_run, load_err, busy, in_ready} !==
        {1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_in_reset: got we=%b addr=%h wd=%h run=%b err=%b busy=%b rdy=%b, required 0 00 00 0 0 0 1",
               mem_we, mem_addr, mem_wdata, cpu_run, load_err, busy, in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({mem_we, cpu_run, load_err, busy, in_ready} !== 5'b00001) begin
      failures++;
      $display("FAIL reset_released: got we=%b run=%b err=%b busy=%b rdy=%b, required 0 0 0 0 1",
               mem_we, cpu_run, load_err, busy, in_ready);
    end
  endtask

  task automatic test_good_frame();
    int w0;
    w0 = writes;
    send_byte(8'h03);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL good_busy_after_len: got %b, required 1", busy);
    end
    send_data(8'h00, 8'h0A);
    send_data(8'h01, 8'h14);
    send_data(8'h02, 8'h1E);
    send_byte(8'h3C);
    in_valid = 1'b0;
    #1;
    checks++;
    if ({cpu_run, in_ready, load_err, busy} !== 4'b1000) begin
      failures++;
      $display("FAIL good_status: got run=%b rdy=%b err=%b busy=%b, required 1 0 0 0",
               cpu_run, in_ready, load_err, busy);
    end
    idle_cycles(2);
    #1;
    checks++;
    if ((writes - w0) !== 3 || sb.size() !== 0) begin
      failures++;
      $display("FAIL good_write_count: got %0d writes (%0d pending), required 3 (0 pending)",
               writes - w0, sb.size());
    end
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b0, 8'h02, 8'h1E}) begin
      failures++;
      $display("FAIL good_hold_port: got we=%b addr=%h wd=%h, required 0 02 1e",
               mem_we, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_bad_chk_stalls();
    int w0;
    w0 = writes;
    send_byte(8'h02);
    idle_cycles(2);
    send_data(8'h00, 8'h05);
    idle_cycles(2);
    send_data(8'h01, 8'h06);
    idle_cycles(2);
    #1;
    checks++;
    if ({busy, cpu_run, load_err} !== 3'b100) begin
      failures++;
      $display("FAIL bad_check_wait: got busy=%b run=%b err=%b, required 1 0 0",
               busy, cpu_run, load_err);
    end
    send_byte(8'h0C);
    in_valid = 1'b0;
    #1;
    checks++;
    if ({load_err, cpu_run, in_ready, busy} !== 4'b1000) begin
      failures++;
      $display("FAIL bad_status: got err=%b run=%b rdy=%b busy=%b, required 1 0 0 0",
               load_err, cpu_run, in_ready, busy);
    end
    for (int i = 0; i < 4; i++) send_byte(8'hA5);
    in_valid = 1'b0;
    idle_cycles(1);
    #1;
    checks++;
    if ({load_err, cpu_run, busy} !== 3'b100 || (writes - w0) !== 2 || sb.size() !== 0) begin
      failures++;
      $display("FAIL bad_ignore_after_err: got err=%b run=%b busy=%b writes=%0d pending=%0d, required 1 0 0 2 0",
               load_err, cpu_run, busy, writes - w0, sb.size());
    end
  endtask

  task automatic test_full_frame();
    int w0;
    logic [7:0] v;
    w0 = writes;
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      send_data(v, v);
    end
    #1;
    checks++;
    if ({busy, cpu_run} !== 2'b10) begin
      failures++;
      $display("FAIL full_before_chk: got busy=%b run=%b, required 1 0", busy, cpu_run);
    end
    send_byte(8'h80);
    in_valid = 1'b0;
    #1;
    checks++;
    if ({cpu_run, load_err} !== 2'b10) begin
      failures++;
      $display("FAIL full_status: got run=%b err=%b, required 1 0", cpu_run, load_err);
    end
    idle_cycles(2);
    #1;
    checks++;
    if ((writes - w0) !== 256 || sb.size() !== 0 || mem_addr !== 8'hFF) begin
      failures++;
      $display("FAIL full_writes: got %0d writes pending=%0d last_addr=%h, required 256 0 ff",
               writes - w0, sb.size(), mem_addr);
    end
  endtask

  task automatic test_reload();
    int w0;
    // From RUN: in_ready is forced low in the reload cycle, cpu_run drops after.
    reload = 1'b1;
    #1;
    checks++;
    if ({in_ready, cpu_run} !== 2'b01) begin
      failures++;
      $display("FAIL reload_cycle: got rdy=%b run=%b, required 0 1", in_ready, cpu_run);
    end
    @(negedge clk);
    reload = 1'b0;
    #1;
    checks++;
    if ({cpu_run, in_ready, busy} !== 3'b010) begin
      failures++;
      $display("FAIL reload_from_run: got run=%b rdy=%b busy=%b, required 0 1 0",
               cpu_run, in_ready, busy);
    end
    // Mid-load reload with a byte presented in the same cycle.
    w0 = writes;
    send_byte(8'h04);
    send_data(8'h00, 8'h11);
    send_data(8'h01, 8'h22);
    in_valid = 1'b1;
    in_data  = 8'h33;
    reload   = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reload_blocks_byte: got rdy=%b, required 0", in_ready);
    end
    @(negedge clk);
    reload   = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, cpu_run, load_err} !== 4'b0100) begin
      failures++;
      $display("FAIL reload_mid_idle: got busy=%b rdy=%b run=%b err=%b, required 0 1 0 0",
               busy, in_ready, cpu_run, load_err);
    end
    idle_cycles(1);
    #1;
    checks++;
    if ((writes - w0) !== 2 || sb.size() !== 0) begin
      failures++;
      $display("FAIL reload_mid_writes: got %0d writes pending=%0d, required 2 0",
               writes - w0, sb.size());
    end
    // Fresh frame after the aborted one.
    send_byte(8'h01);
    send_data(8'h00, 8'h7F);
    send_byte(8'h7F);
    in_valid = 1'b0;
    #1;
    checks++;
    if ({cpu_run, load_err} !== 2'b10) begin
      failures++;
      $display("FAIL reload_new_frame: got run=%b err=%b, required 1 0", cpu_run, load_err);
    end
    pulse_reload();
    #1;
    checks++;
    if (cpu_run !== 1'b0) begin
      failures++;
      $display("FAIL reload_drop_run: got %b, required 0", cpu_run);
    end
  endtask

  task automatic test_async_reset();
    int w0;
    w0 = writes;
    send_byte(8'h05);
    send_data(8'h00, 8'h01);
    send_data(8'h01, 8'h02);
    // Byte 03 is presented; reset lands on the edge that would accept it.
    in_valid = 1'b1;
    in_data  = 8'h03;
    @(posedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_wdata, busy, in_ready, cpu_run, load_err} !==
        {1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: got we=%b addr=%h wd=%h busy=%b rdy=%b run=%b err=%b, required 0 00 00 0 1 0 0",
               mem_we, mem_addr, mem_wdata, busy, in_ready, cpu_run, load_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ((writes - w0) !== 2 || sb.size() !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_writes: got %0d writes pending=%0d busy=%b, required 2 0 0",
               writes - w0, sb.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    pulse_reload();
    test_bad_chk_stalls();
    pulse_reload();
    test_full_frame();
    test_reload();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
